// File: rtl/gyro_pkg.sv
// Shared types and constants for the gyro SPI serf: frame FSM states,
// register map addresses and STATUS bit positions.
package gyro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    // Command byte captured at the 8th SCLK rise.
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
    } spi_cmd_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned BIT_CNT_W  = 4;

    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
    localparam logic [6:0] ADDR_CTRL5     = 7'h14;
    localparam logic [6:0] ADDR_STATUS    = 7'h1E;
    localparam logic [6:0] ADDR_OUTZ_L    = 7'h26;
    localparam logic [6:0] ADDR_OUTZ_H    = 7'h27;

    localparam logic [2:0] STATUS_GDA_BIT = 3'd0;
    localparam logic [2:0] STATUS_OVR_BIT = 3'd1;
    localparam logic [2:0] INT1_DRDY_BIT  = 3'd1;

    function automatic logic [7:0] status_byte(input logic gda, input logic ovr);
        logic [7:0] s;
        s                 = 8'h00;
        s[STATUS_GDA_BIT] = gda;
        s[STATUS_OVR_BIT] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin plus rise/fall detection
// on the synchronized copy.
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset low so a select held low across reset cannot fake a fresh fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/gyro_serf.sv
// SPI mode-0 serf exposing a small gyro register map; samples yaw_in at a
// fixed output data rate and flags data-ready on INT.
module gyro_serf
    import gyro_pkg::*;
#(
    parameter int unsigned ODR_CLKS     = 1024,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] yaw_in,
    output logic        INT
);

    localparam int unsigned           ODR_W    = (ODR_CLKS > 1) ? $clog2(ODR_CLKS) : 1;
    localparam logic [ODR_W-1:0]      ODR_LAST = ODR_W'(ODR_CLKS - 1);
    localparam logic [BIT_CNT_W-1:0]  CMD_LAST = BIT_CNT_W'(FRAME_BITS / 2 - 1);
    localparam logic [BIT_CNT_W-1:0]  DAT_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    logic ss_rise_c;
    logic ss_fall_c;
    logic sclk_rise_c;
    logic sclk_fall_c;
    logic mosi_meta_q;
    logic mosi_q;

    spi_edge_sync u_ss_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (SS_n),
        .rise_c   (ss_rise_c),
        .fall_c   (ss_fall_c)
    );

    spi_edge_sync u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (SCLK),
        .rise_c   (sclk_rise_c),
        .fall_c   (sclk_fall_c)
    );

    // MOSI needs no edge detect, only the same two-flop latency as SCLK.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_meta_q <= MOSI;
            mosi_q      <= mosi_meta_q;
        end
    end

    spi_state_e           state_q;
    spi_state_e           state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [6:0]           shift_q;
    logic [7:0]           rx_byte_c;
    spi_cmd_t             cmd_q;
    logic [7:0]           tx_q;
    logic [7:0]           rd_data_c;

    logic shift_en_c;
    logic load_cmd_c;
    logic end_frame_c;
    logic tx_shift_c;

    assign rx_byte_c = {shift_q, mosi_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ss_fall_c) state_d = ST_CMD;
            ST_CMD: begin
                if (ss_rise_c) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise_c && bit_cnt_q == CMD_LAST) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ss_rise_c) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise_c && bit_cnt_q == DAT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (ss_rise_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame strobes; an SS_n rise in the same cycle overrides any SCLK edge.
    always_comb begin
        shift_en_c  = 1'b0;
        load_cmd_c  = 1'b0;
        end_frame_c = 1'b0;
        tx_shift_c  = 1'b0;
        unique case (state_q)
            ST_CMD: begin
                if (!ss_rise_c && sclk_rise_c) begin
                    shift_en_c = 1'b1;
                    load_cmd_c = (bit_cnt_q == CMD_LAST);
                end
            end
            ST_DATA: begin
                if (!ss_rise_c) begin
                    shift_en_c  = sclk_rise_c;
                    end_frame_c = sclk_rise_c && (bit_cnt_q == DAT_LAST);
                    tx_shift_c  = sclk_fall_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
        end else if (shift_en_c) begin
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            shift_q   <= rx_byte_c[6:0];
        end
    end

    // Read data is fetched at the 8th rise and shifted out on later falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= '0;
            tx_q  <= 8'h00;
        end else if (load_cmd_c) begin
            cmd_q <= spi_cmd_t'(rx_byte_c);
            tx_q  <= rx_byte_c[7] ? rd_data_c : 8'h00;
        end else if (tx_shift_c) begin
            tx_q <= {tx_q[6:0], 1'b0};
        end
    end

    logic miso_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            miso_q <= 1'b0;
        end else if (state_d != ST_DATA) begin
            miso_q <= 1'b0;
        end else if (tx_shift_c) begin
            miso_q <= tx_q[7];
        end
    end

    assign MISO = miso_q;

    logic [7:0]       int1_ctrl_q;
    logic [7:0]       int1_ctrl_d;
    logic [7:0]       ctrl2_g_q;
    logic [7:0]       ctrl2_g_d;
    logic [7:0]       ctrl5_q;
    logic [7:0]       ctrl5_d;
    logic [15:0]      sample_q;
    logic [7:0]       shadow_q;
    logic             shadow_vld_q;
    logic             clr_pend_q;
    logic             gda_q;
    logic             gda_d;
    logic             ovr_q;
    logic             ovr_d;
    logic             int_q;
    logic [ODR_W-1:0] odr_cnt_q;
    logic             gyro_en_c;
    logic             tick_c;
    logic             wr_commit_c;
    logic             rd_done_c;
    logic             status_clr_c;

    assign wr_commit_c  = end_frame_c && !cmd_q.rw;
    assign rd_done_c    = end_frame_c && cmd_q.rw;
    assign status_clr_c = ss_rise_c && clr_pend_q;
    assign gyro_en_c    = (ctrl2_g_q != 8'h00);
    assign tick_c       = gyro_en_c && (odr_cnt_q == ODR_LAST);

    always_comb begin
        rd_data_c = 8'h00;
        case (rx_byte_c[6:0])
            ADDR_INT1_CTRL: rd_data_c = int1_ctrl_q;
            ADDR_WHO_AM_I:  rd_data_c = WHO_AM_I_VAL;
            ADDR_CTRL2_G:   rd_data_c = ctrl2_g_q;
            ADDR_CTRL5:     rd_data_c = ctrl5_q;
            ADDR_STATUS:    rd_data_c = status_byte(gda_q, ovr_q);
            ADDR_OUTZ_L:    rd_data_c = sample_q[7:0];
            ADDR_OUTZ_H:    rd_data_c = shadow_vld_q ? shadow_q : sample_q[15:8];
            default:        rd_data_c = 8'h00;
        endcase
    end

    always_comb begin
        int1_ctrl_d = int1_ctrl_q;
        ctrl2_g_d   = ctrl2_g_q;
        ctrl5_d     = ctrl5_q;
        if (wr_commit_c) begin
            case (cmd_q.addr)
                ADDR_INT1_CTRL: int1_ctrl_d = rx_byte_c;
                ADDR_CTRL2_G:   ctrl2_g_d   = rx_byte_c;
                ADDR_CTRL5:     ctrl5_d     = rx_byte_c;
                default: ;
            endcase
        end
    end

    // A tick landing on the clear wins: fresh data ready, overrun forgotten.
    always_comb begin
        gda_d = gda_q;
        ovr_d = ovr_q;
        if (tick_c) begin
            gda_d = 1'b1;
            ovr_d = status_clr_c ? 1'b0 : (gda_q | ovr_q);
        end else if (status_clr_c) begin
            gda_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int1_ctrl_q <= 8'h00;
            ctrl2_g_q   <= 8'h00;
            ctrl5_q     <= 8'h00;
            gda_q       <= 1'b0;
            ovr_q       <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            int1_ctrl_q <= int1_ctrl_d;
            ctrl2_g_q   <= ctrl2_g_d;
            ctrl5_q     <= ctrl5_d;
            gda_q       <= gda_d;
            ovr_q       <= ovr_d;
            int_q       <= gda_d & int1_ctrl_d[INT1_DRDY_BIT];
        end
    end

    assign INT = int_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            odr_cnt_q <= '0;
            sample_q  <= 16'h0000;
        end else if (!gyro_en_c || tick_c) begin
            odr_cnt_q <= '0;
            if (tick_c) sample_q <= yaw_in;
        end else begin
            odr_cnt_q <= odr_cnt_q + ODR_W'(1);
        end
    end

    // High-byte shadow keeps OUTZ_L/OUTZ_H coherent across a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= 8'h00;
            shadow_vld_q <= 1'b0;
            clr_pend_q   <= 1'b0;
        end else begin
            if (rd_done_c && cmd_q.addr == ADDR_OUTZ_L) begin
                shadow_q     <= sample_q[15:8];
                shadow_vld_q <= 1'b1;
            end else if (rd_done_c && cmd_q.addr == ADDR_OUTZ_H) begin
                shadow_vld_q <= 1'b0;
            end
            if (ss_rise_c) begin
                clr_pend_q <= 1'b0;
            end else if (rd_done_c && cmd_q.addr == ADDR_OUTZ_H) begin
                clr_pend_q <= 1'b1;
            end
        end
    end

endmodule
